// File: rtl/poly_mod_sub_stream.sv
// rtl/poly_mod_sub_stream.sv - streaming coefficient-wise (a - b) mod q over two source memories
module poly_mod_sub_stream #(
    parameter int K    = 54,
    parameter int LOGN = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic [K-1:0]    q,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr,
    input  logic [K-1:0]    rda_data,
    input  logic [K-1:0]    rdb_data,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr,
    output logic [K-1:0]    wr_data,
    output logic            busy,
    output logic            done
);

    localparam logic [LOGN-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] cur;
    logic            accept;
    logic            issue;
    logic [K-1:0]    q_r;

    // Valid/address tags travelling alongside the memory and subtract stages
    logic            m_v, s1_v;
    logic [LOGN-1:0] m_addr, s1_addr;
    logic [K:0]      d;

    // The first read is issued on the same edge that accepts start, so the
    // address used then is zero regardless of the stale counter.
    always_comb begin
        accept   = (state == IDLE) && start;
        cur      = accept ? '0 : cnt;
        issue    = !hold && (accept || (state == RUN));
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (issue && cur == LAST) ? DRAIN : RUN;
            RUN:     if (issue && cur == LAST) state_nx = DRAIN;
            DRAIN:   if (wr_en && wr_addr == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            m_v     <= 1'b0;
            s1_v    <= 1'b0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            rd_en <= issue;
            if (issue) begin
                rd_addr <= cur;
                cnt     <= cur + 1'b1;
            end else if (accept) begin
                cnt <= '0;
            end
            m_v   <= rd_en;
            s1_v  <= m_v;
            wr_en <= s1_v;
            busy  <= (state_nx == RUN) || (state_nx == DRAIN);
            done  <= (state_nx == DONE);
        end
    end

    // Datapath carries no reset; its validity is tracked by the tags above.
    always_ff @(posedge clk) begin
        if (accept) q_r <= q;
        m_addr  <= rd_addr;
        s1_addr <= m_addr;
        d       <= {1'b0, rda_data} - {1'b0, rdb_data};
        wr_addr <= s1_addr;
        wr_data <= d[K] ? (d[K-1:0] + q_r) : d[K-1:0];
    end

endmodule
